// File: rtl/pwm_capture_pkg.sv
// ---------------------------------------------------------------------------
// pwm_capture_pkg
// Shared types for the PWM capture block.
//   cap_state_e : measurement FSM state (IDLE, HIGH, LOW)
// ---------------------------------------------------------------------------
package pwm_capture_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } cap_state_e;

endpackage

// File: rtl/pwm_capture_in_cond.sv
// ---------------------------------------------------------------------------
// pwm_in_cond
// Conditions an asynchronous pin input: synchroniser, optional glitch filter
// (built only with PWM_CAPTURE_FILTER_EN), then a registered edge detector.
// s, rise and fall are all registered and mutually aligned: in the cycle
// rise is high, s is already 1 (and 0 for fall).
// Parameters:
//   SYNC_STAGES : synchroniser depth (>= 2)
//   FILT_LEN    : cycles of stable differing level before the filtered level
//                 follows (present only when the filter is built in)
// Ports:
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   pwm_in in  asynchronous pin level
//   s      out conditioned level
//   rise   out one-cycle pulse on a 0->1 transition of s
//   fall   out one-cycle pulse on a 1->0 transition of s
// ---------------------------------------------------------------------------
module pwm_in_cond #(
  parameter int SYNC_STAGES = 2
`ifdef PWM_CAPTURE_FILTER_EN
  , parameter int FILT_LEN  = 4
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pwm_in,
  output logic s,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   lvl;

  // synchroniser
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= '0;
    else        sync <= {sync[SYNC_STAGES-2:0], pwm_in};
  end

`ifdef PWM_CAPTURE_FILTER_EN
  localparam int FW = $clog2(FILT_LEN + 1);

  logic          filt;
  logic [FW-1:0] fcnt;

  // filtered level follows only after FILT_LEN consecutive differing cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt <= 1'b0;
      fcnt <= '0;
    end else if (sync[SYNC_STAGES-1] != filt) begin
      if (fcnt == FW'(FILT_LEN - 1)) begin
        filt <= sync[SYNC_STAGES-1];
        fcnt <= '0;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end else begin
      fcnt <= '0;
    end
  end

  assign lvl = filt;
`else
  assign lvl = sync[SYNC_STAGES-1];
`endif

  // edge detect; registered so that s/rise/fall line up
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s    <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s    <= lvl;
      rise <= lvl & ~s;
      fall <= ~lvl & s;
    end
  end

endmodule

// File: rtl/pwm_capture.sv
// ---------------------------------------------------------------------------
// pwm_capture
// Measures an external PWM waveform: period (rise to rise) and high time
// (rise to fall) in clk cycles, reported once per full period, plus detection
// of an input that has stopped toggling.
// Optional glitch filter: define PWM_CAPTURE_FILTER_EN (adds FILT_LEN param).
// Parameters:
//   CNT_W       : counter/output width
//   TIMEOUT     : cycles without a required edge before stuck_o (2..2**CNT_W-1)
//   SYNC_STAGES : input synchroniser depth (>= 2)
//   FILT_LEN    : glitch filter length (only with PWM_CAPTURE_FILTER_EN)
// Ports:
//   clk         in  system clock
//   rst_n       in  asynchronous active-low reset
//   en_i        in  capture enable; low aborts and holds in IDLE
//   pwm_in      in  asynchronous PWM input
//   period_o    out last measured period
//   high_o      out last measured high time
//   valid_o     out one-cycle pulse when period_o/high_o update
//   stuck_o     out input has had no required edge for TIMEOUT cycles
//   stuck_lvl_o out input level captured when stuck_o was set
// ---------------------------------------------------------------------------
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int TIMEOUT     = (1 << CNT_W) - 1,
  parameter int SYNC_STAGES = 2
`ifdef PWM_CAPTURE_FILTER_EN
  , parameter int FILT_LEN  = 4
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o,
  output logic             valid_o,
  output logic             stuck_o,
  output logic             stuck_lvl_o
);

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

  logic s, rise, fall;

  pwm_in_cond #(
    .SYNC_STAGES(SYNC_STAGES)
`ifdef PWM_CAPTURE_FILTER_EN
    , .FILT_LEN (FILT_LEN)
`endif
  ) u_cond (
    .clk   (clk),
    .rst_n (rst_n),
    .pwm_in(pwm_in),
    .s     (s),
    .rise  (rise),
    .fall  (fall)
  );

  cap_state_e       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic [CNT_W-1:0] hi_cnt, hi_cnt_n;
  logic [CNT_W-1:0] period_n, high_n;
  logic             valid_n, stuck_n, stuck_lvl_n;

  // counter saturates at TIMEOUT so it can never wrap
  assign cnt_inc = (cnt == TMO) ? cnt : cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      hi_cnt      <= '0;
      period_o    <= '0;
      high_o      <= '0;
      valid_o     <= 1'b0;
      stuck_o     <= 1'b0;
      stuck_lvl_o <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      hi_cnt      <= hi_cnt_n;
      period_o    <= period_n;
      high_o      <= high_n;
      valid_o     <= valid_n;
      stuck_o     <= stuck_n;
      stuck_lvl_o <= stuck_lvl_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    hi_cnt_n    = hi_cnt;
    period_n    = period_o;
    high_n      = high_o;
    valid_n     = 1'b0;
    stuck_n     = stuck_o;
    stuck_lvl_n = stuck_lvl_o;

    if (!en_i) begin
      state_n = IDLE;
      cnt_n   = '0;
      stuck_n = 1'b0;
    end else begin
      // edges always take priority over the timeout check
      unique case (state)
        IDLE: begin
          if (rise) begin
            state_n = HIGH;
            cnt_n   = CNT_W'(1);
          end else if (fall) begin
            cnt_n = '0;
          end else if (cnt == TMO) begin
            // covers an input stuck since reset or since a previous timeout
            stuck_n     = 1'b1;
            stuck_lvl_n = s;
          end else begin
            cnt_n = cnt_inc;
          end
        end
        HIGH: begin
          if (fall) begin
            state_n  = LOW;
            hi_cnt_n = cnt;
            cnt_n    = cnt_inc;
          end else if (rise) begin
            // a lost low phase: restart the measurement from this rise
            cnt_n = CNT_W'(1);
          end else if (cnt == TMO) begin
            state_n     = IDLE;
            cnt_n       = '0;
            stuck_n     = 1'b1;
            stuck_lvl_n = s;
          end else begin
            cnt_n = cnt_inc;
          end
        end
        LOW: begin
          if (rise) begin
            state_n  = HIGH;
            cnt_n    = CNT_W'(1);
            period_n = cnt;
            high_n   = hi_cnt;
            valid_n  = 1'b1;
            stuck_n  = 1'b0;
          end else if (!fall && cnt == TMO) begin
            state_n     = IDLE;
            cnt_n       = '0;
            stuck_n     = 1'b1;
            stuck_lvl_n = s;
          end else begin
            cnt_n = cnt_inc;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

endmodule
